imem_port_arbiter: RTL and testbench

//  Shares one single-port, word-addressed instruction memory between two requesters.

---
 rtl/imem_port_arbiter_pkg.sv | 7 +
 rtl/imem_port_arbiter_if.sv | 24 ++
 rtl/imem_port_arbiter_rr_arb2.sv | 14 +
 rtl/imem_port_arbiter.sv | 45 ++++
 tb/tb_imem_port_arbiter.sv | 136 +++++++++++++
 5 files changed

// File: rtl/imem_port_arbiter_pkg.sv
// imem_pkg: shared types and sizing for the instruction-memory port arbiter
package imem_pkg;
  localparam int IMEM_DEPTH_WORDS = 1024;
  localparam int IMEM_XLEN = 32;
  typedef enum logic {PORT_F, PORT_D} port_e;
  typedef struct packed {port_e owner; logic err; logic we;} imem_s1_t;
endpackage

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, debug and memory buses of the arbiter
interface imem_port_arbiter_if #(
  parameter int DEPTH_WORDS = imem_pkg::IMEM_DEPTH_WORDS,
  parameter int XLEN = imem_pkg::IMEM_XLEN
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  logic f_req_valid, f_req_ready, f_flush, f_rsp_valid, f_rsp_err;
  logic [XLEN-1:0] f_req_addr, f_rsp_data;
  logic d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
  logic [XLEN-1:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic mem_en, mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [XLEN-1:0] mem_wdata, mem_rdata;
  modport slave (
    input f_req_valid, f_req_addr, f_flush, d_req_valid, d_req_we, d_req_addr, d_req_wdata, mem_rdata,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err, d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_en, mem_we, mem_idx, mem_wdata
  );
  modport master (
    output f_req_valid, f_req_addr, f_flush, d_req_valid, d_req_we, d_req_addr, d_req_wdata, mem_rdata,
    input f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err, d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input mem_en, mem_we, mem_idx, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; last holds the port granted most recently
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one synchronous-read instruction memory between fetch (F) and debug (D)
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int XLEN = IMEM_XLEN
) (
  input logic clk,
  input logic rst_n,
  imem_port_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  logic [1:0] gnt;
  logic [XLEN-1:0] addr, rdata;
  logic err, s1_vld, f_live, d_live;
  imem_s1_t s1;
  rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .req({bus.d_req_valid, bus.f_req_valid} & {2{rst_n}}), .gnt(gnt));
  assign addr = gnt[1] ? bus.d_req_addr : bus.f_req_addr;
  // upper bits set means the byte address is past the end of the array
  assign err = (|addr[1:0]) | (|addr[XLEN-1:IDX_W+2]);
  assign bus.f_req_ready = gnt[0];
  assign bus.d_req_ready = gnt[1];
  assign bus.mem_en = (|gnt) & ~err;
  assign bus.mem_we = (|gnt) & ~err & gnt[1] & bus.d_req_we;
  assign bus.mem_idx = addr[IDX_W+1:2];
  assign bus.mem_wdata = bus.d_req_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1 <= '0;
    end else begin
      s1_vld <= |gnt;
      if (|gnt) s1 <= '{owner: gnt[1] ? PORT_D : PORT_F, err: err, we: gnt[1] & bus.d_req_we};
    end
  // a flush in the response cycle drops the fetch granted one cycle earlier
  assign f_live = s1_vld & (s1.owner == PORT_F) & ~bus.f_flush;
  assign d_live = s1_vld & (s1.owner == PORT_D);
  assign rdata = (s1.err | s1.we) ? '0 : bus.mem_rdata;
  assign bus.f_rsp_valid = f_live;
  assign bus.f_rsp_data = f_live ? rdata : '0;
  assign bus.f_rsp_err = f_live & s1.err;
  assign bus.d_rsp_valid = d_live;
  assign bus.d_rsp_data = d_live ? rdata : '0;
  assign bus.d_rsp_err = d_live & s1.err;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: scoreboard bench with a cycle-level reference model of arbitration and memory
module tb_imem_port_arbiter;
  import imem_pkg::*;
  localparam int DW = IMEM_DEPTH_WORDS;
  typedef struct {int t; logic [31:0] data; logic err;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  imem_port_arbiter_if bus();
  imem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] mem [DW];
  logic [31:0] ref_mem [DW];
  bit mem_init = 1'b0;
  exp_t fq[$], dq[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic last_d = 1'b1, exp_frdy = 1'b0, exp_drdy = 1'b0, exp_en = 1'b0;
  always @(posedge clk)
    if (!mem_init) begin
      for (int i = 0; i < DW; i++) mem[i] <= 32'(i);
      mem_init <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_idx] <= bus.mem_wdata;
      bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : mem[bus.mem_idx];
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic rsp_chk(input string p, input logic v, input logic [31:0] d, input logic e, ref exp_t q[$]);
    if (q.size() != 0 && q[0].t == cyc) begin
      chk({p, "_rsp_valid"}, 32'(v), 32'd1);
      chk({p, "_rsp_data"}, d, q[0].data);
      chk({p, "_rsp_err"}, 32'(e), 32'(q[0].err));
      void'(q.pop_front());
    end else begin
      chk({p, "_rsp_valid"}, 32'(v), 32'd0);
      if (!rst_n) begin
        chk({p, "_rsp_data_rst"}, d, 32'd0);
        chk({p, "_rsp_err_rst"}, 32'(e), 32'd0);
      end
    end
  endtask
  always @(negedge clk) begin
    chk("f_req_ready", 32'(bus.f_req_ready), 32'(exp_frdy));
    chk("d_req_ready", 32'(bus.d_req_ready), 32'(exp_drdy));
    chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
    rsp_chk("f", bus.f_rsp_valid, bus.f_rsp_data, bus.f_rsp_err, fq);
    rsp_chk("d", bus.d_rsp_valid, bus.d_rsp_data, bus.d_rsp_err, dq);
  end
  task automatic step(input logic rn, input logic fv, input logic [31:0] fa, input logic fl,
                      input logic dv, input logic dwe, input logic [31:0] da, input logic [31:0] dw);
    bit take_d, e;
    logic [31:0] a;
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rn;
    bus.f_req_valid = fv; bus.f_req_addr = fa; bus.f_flush = fl;
    bus.d_req_valid = dv; bus.d_req_we = dwe; bus.d_req_addr = da; bus.d_req_wdata = dw;
    cyc++;
    if (!rn) begin
      fq.delete(); dq.delete(); last_d = 1'b1;
    end
    if (fl && fq.size() != 0 && fq[0].t == cyc) void'(fq.pop_front());
    exp_frdy = 1'b0; exp_drdy = 1'b0; exp_en = 1'b0;
    if (rn && (fv || dv)) begin
      take_d = dv && (!fv || !last_d);
      a = take_d ? da : fa;
      e = (a % 4 != 0) || (a >= 32'(DW * 4));
      x.t = cyc + 1; x.err = e; x.data = 32'd0;
      if (!e) begin
        if (take_d && dwe) ref_mem[a / 4] = dw;
        else x.data = ref_mem[a / 4];
      end
      exp_en = !e;
      if (take_d) begin exp_drdy = 1'b1; dq.push_back(x); end
      else begin exp_frdy = 1'b1; fq.push_back(x); end
      last_d = take_d;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask
  function automatic logic [31:0] rnd_addr();
    int r = int'($urandom_range(19));
    if (r < 16) return 32'(r * 4);
    if (r == 16) return 32'(($urandom_range(DW - 1) * 4) | $urandom_range(1, 3));
    if (r == 17) return 32'(DW * 4 + $urandom_range(255) * 4);
    if (r == 18) return 32'((DW - 1) * 4);
    return 32'hFFFF_FFFC;
  endfunction
  initial begin
    logic fv = 1'b0, dv = 1'b0, dwe = 1'b0;
    logic [31:0] fa = 32'd0, da = 32'd0, dw = 32'd0;
    for (int i = 0; i < DW; i++) ref_mem[i] = 32'(i);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h24, 32'd0);
    idle(1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);
    step(1'b1, 1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'(DW * 4), 32'h1234_5678);
    step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);
    step(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);
    step(1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'h1C, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(2);
    step(1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h24, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'h28, 1'b0, 1'b1, 1'b0, 32'h2C, 32'd0);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      if (!fv && $urandom_range(3) != 0) begin fv = 1'b1; fa = rnd_addr(); end
      if (!dv && $urandom_range(2) == 0) begin
        dv = 1'b1; dwe = 1'($urandom_range(1)); da = rnd_addr(); dw = $urandom;
      end
      step(1'b1, fv, fa, $urandom_range(6) == 0, dv, dwe, da, dw);
      if (exp_frdy) fv = 1'b0;
      if (exp_drdy) dv = 1'b0;
    end
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
